// File: rtl/ecpri_pkg.sv
// Shared eCPRI constants, header offsets and receive FSM states.
// Used by the RMA receive and transmit paths.
package ecpri_pkg;

  localparam logic [3:0] ECPRI_REV = 4'h1;
  localparam logic [7:0] MSG_RMA   = 8'd4;

  localparam logic [3:0] RW_READ  = 4'h0;
  localparam logic [3:0] RW_WRITE = 4'h1;
  localparam logic [3:0] RMA_REQ  = 4'h0;

  localparam int RMA_HDR_BYTES = 12;

  localparam logic [3:0] OFF_MSG     = 4'd1;
  localparam logic [3:0] OFF_PSZ_HI  = 4'd2;
  localparam logic [3:0] OFF_PSZ_LO  = 4'd3;
  localparam logic [3:0] OFF_ID      = 4'd4;
  localparam logic [3:0] OFF_RW      = 4'd5;
  localparam logic [3:0] OFF_EL_HI   = 4'd6;
  localparam logic [3:0] OFF_EL_LO   = 4'd7;
  localparam logic [3:0] OFF_ADDR    = 4'd8;
  localparam logic [3:0] OFF_LEN_HI  = 4'd14;
  localparam logic [3:0] OFF_LEN_LO  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RMA,
    S_WDATA,
    S_RD_END,
    S_WR_END,
    S_DROP
  } state_t;

  function automatic logic rev_ok(input logic [7:0] b);
    return (b[7:4] == ECPRI_REV) && !b[0];
  endfunction

endpackage

// File: rtl/ecpri_rma_rx.sv
// Byte-serial eCPRI receiver: parses RMA requests, writes payload
// to local memory and signals completed requests to the transmitter.
module ecpri_rma_rx
  import ecpri_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              send_write_resp,
  output logic              send_read_resp,
  output logic [7:0]        tx_payload_len,
  output logic [7:0]        rma_id,
  output logic [15:0]       element_id,
  output logic              hdr_err,
  output logic              busy
);

  state_t state, state_nxt;

  logic [3:0]        cnt;
  logic [7:0]        dcnt;
  logic [15:0]       psize;
  logic [15:0]       len;
  logic [15:0]       elem;
  logic [7:0]        id;
  logic              wr;
  logic [ADDR_W-1:0] base;

  logic        err_set;
  logic        in_frame;
  logic        rw_bad;
  logic        len_bad;
  logic        last;
  logic [15:0] len_now;

  assign in_frame = (state == S_HDR) || (state == S_RMA) ||
                    (state == S_WDATA) || (state == S_DROP);

  assign rw_bad = (rx_data[3:0] != RMA_REQ) ||
                  ((rx_data[7:4] != RW_READ) &&
                   (rx_data[7:4] != RW_WRITE));

  assign len_now = {len[15:8], rx_data};
  assign last    = (dcnt == 8'(len[7:0] - 8'd1));

  // Payload size must cover the RMA header plus write data exactly
  always_comb begin
    len_bad = 1'b0;
    if (len_now == 16'd0 || len_now > 16'(MAX_LEN))
      len_bad = 1'b1;
    else if (wr)
      len_bad = {1'b0, psize} !=
                17'(RMA_HDR_BYTES) + {1'b0, len_now};
    else
      len_bad = psize != 16'(RMA_HDR_BYTES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    if (state == S_RD_END || state == S_WR_END)
      state_nxt = S_IDLE;
    if (rx_valid && rx_sof) begin
      err_set = in_frame;
      if (!rev_ok(rx_data) || rx_eof) begin
        err_set   = 1'b1;
        state_nxt = rx_eof ? S_IDLE : S_DROP;
      end else begin
        state_nxt = S_HDR;
      end
    end else if (rx_valid) begin
      unique case (state)
        S_HDR: begin
          if (cnt == OFF_MSG && rx_data != MSG_RMA) begin
            state_nxt = rx_eof ? S_IDLE : S_DROP;
          end else if (rx_eof) begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end else if (cnt == OFF_PSZ_LO) begin
            state_nxt = S_RMA;
          end
        end
        S_RMA: begin
          if ((cnt == OFF_RW && rw_bad) ||
              (cnt == OFF_LEN_LO && len_bad)) begin
            err_set   = 1'b1;
            state_nxt = rx_eof ? S_IDLE : S_DROP;
          end else if (cnt == OFF_LEN_LO) begin
            if (wr) begin
              err_set   = rx_eof;
              state_nxt = rx_eof ? S_IDLE : S_WDATA;
            end else begin
              err_set   = !rx_eof;
              state_nxt = rx_eof ? S_RD_END : S_DROP;
            end
          end else if (rx_eof) begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_WDATA: begin
          if (last) begin
            err_set   = !rx_eof;
            state_nxt = rx_eof ? S_WR_END : S_DROP;
          end else if (rx_eof) begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_DROP: begin
          if (rx_eof) state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = state != S_IDLE;
    send_write_resp = state == S_WR_END;
    send_read_resp  = state == S_RD_END;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      dcnt           <= '0;
      psize          <= '0;
      len            <= '0;
      elem           <= '0;
      id             <= '0;
      wr             <= 1'b0;
      base           <= '0;
      mem_wr_en      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      tx_payload_len <= '0;
      rma_id         <= '0;
      element_id     <= '0;
      hdr_err        <= 1'b0;
    end else begin
      hdr_err   <= err_set;
      mem_wr_en <= 1'b0;
      if (rx_valid && rx_sof) begin
        cnt <= 4'd1;
      end else if (rx_valid &&
                   (state == S_HDR || state == S_RMA)) begin
        cnt <= cnt + 4'd1;
        case (cnt)
          OFF_PSZ_HI: psize[15:8] <= rx_data;
          OFF_PSZ_LO: psize[7:0]  <= rx_data;
          OFF_ID:     id          <= rx_data;
          OFF_RW:     wr          <= rx_data[7:4] == RW_WRITE;
          OFF_EL_HI:  elem[15:8]  <= rx_data;
          OFF_EL_LO:  elem[7:0]   <= rx_data;
          OFF_LEN_HI: len[15:8]   <= rx_data;
          OFF_LEN_LO: len[7:0]    <= rx_data;
          default: ;
        endcase
        // Only the low ADDR_W bits of the 48-bit address survive
        if (cnt >= OFF_ADDR && cnt < OFF_LEN_HI)
          base <= ADDR_W'({base, rx_data});
      end
      if (state != S_WDATA && state_nxt == S_WDATA)
        dcnt <= '0;
      if (rx_valid && !rx_sof && state == S_WDATA) begin
        mem_wr_en <= 1'b1;
        mem_addr  <= base + ADDR_W'(dcnt);
        mem_wdata <= rx_data;
        dcnt      <= dcnt + 8'd1;
      end
      if (state_nxt == S_RD_END || state_nxt == S_WR_END) begin
        tx_payload_len <= (state == S_RMA) ? rx_data : len[7:0];
        rma_id         <= id;
        element_id     <= elem;
      end
    end
  end

endmodule

// File: tb/tb_ecpri_rma_rx.sv
// Scoreboard bench for ecpri_rma_rx: frames are built byte by byte,
// expected memory writes and pulses queued, then matched on output.
module tb_ecpri_rma_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        send_write_resp;
  logic        send_read_resp;
  logic [7:0]  tx_payload_len;
  logic [7:0]  rma_id;
  logic [15:0] element_id;
  logic        hdr_err;
  logic        busy;

  ecpri_rma_rx #(.ADDR_W(8), .MAX_LEN(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_sof          (rx_sof),
    .rx_eof          (rx_eof),
    .mem_wr_en       (mem_wr_en),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .send_write_resp (send_write_resp),
    .send_read_resp  (send_read_resp),
    .tx_payload_len  (tx_payload_len),
    .rma_id          (rma_id),
    .element_id      (element_id),
    .hdr_err         (hdr_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] k;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  localparam logic [31:0] EV_WR  = 32'd0;
  localparam logic [31:0] EV_WRS = 32'd1;
  localparam logic [31:0] EV_RDS = 32'd2;
  localparam logic [31:0] EV_ERR = 32'd3;

  ev_t        sb[$];
  logic [7:0] fr[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         stall  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input logic [31:0] k,
                         input logic [31:0] a,
                         input logic [31:0] b);
    ev_t e;
    e.k = k;
    e.a = a;
    e.b = b;
    sb.push_back(e);
  endtask

  task automatic pop_ev(input logic [31:0] k,
                        input logic [31:0] a,
                        input logic [31:0] b);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event", k, 32'hdead);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", k, e.k);
    chk("ev_a", a, e.a);
    chk("ev_b", b, e.b);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en)
        pop_ev(EV_WR, 32'(mem_addr), 32'(mem_wdata));
      if (hdr_err)
        pop_ev(EV_ERR, 32'd0, 32'd0);
      if (send_write_resp)
        pop_ev(EV_WRS, 32'(tx_payload_len),
               {8'd0, element_id, rma_id});
      if (send_read_resp)
        pop_ev(EV_RDS, 32'(tx_payload_len),
               {8'd0, element_id, rma_id});
      if (send_write_resp || send_read_resp) begin
        chk("resp_excl", 32'(send_write_resp & send_read_resp), 0);
        chk("err_resp_excl", 32'(hdr_err), 0);
      end
    end
  end

  task automatic mk(input logic [7:0]  b0,
                    input logic [7:0]  mt,
                    input logic [15:0] ps,
                    input logic [7:0]  id,
                    input logic [7:0]  rwb,
                    input logic [15:0] el,
                    input logic [47:0] ad,
                    input logic [15:0] ln);
    fr.delete();
    fr.push_back(b0);
    fr.push_back(mt);
    fr.push_back(ps[15:8]);
    fr.push_back(ps[7:0]);
    fr.push_back(id);
    fr.push_back(rwb);
    fr.push_back(el[15:8]);
    fr.push_back(el[7:0]);
    for (int i = 5; i >= 0; i--)
      fr.push_back(ad[i*8 +: 8]);
    fr.push_back(ln[15:8]);
    fr.push_back(ln[7:0]);
  endtask

  task automatic push_wr(input logic [7:0] base,
                         input int n,
                         input logic [7:0] d0);
    logic [7:0] a;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      d = d0 + 8'(i);
      fr.push_back(d);
      push_ev(EV_WR, 32'(a), 32'(d));
    end
  endtask

  task automatic send(input int eof_at);
    for (int i = 0; i < fr.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = fr[i];
      rx_sof   = (i == 0);
      rx_eof   = (i == eof_at);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_sof   = 1'b0;
      rx_eof   = 1'b0;
      if (stall && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_eof   = 1'b0;
    idle(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_len", 32'(tx_payload_len), 0);
    chk("rst_err", 32'(hdr_err), 0);
    chk("rst_id", 32'(rma_id), 0);
    chk("rst_elem", 32'(element_id), 0);
    reset = 1'b0;
    idle(1);

    // Write, back-to-back data bytes
    mk(8'h10, 8'h04, 16'd16, 8'h5A, 8'h10, 16'h0102, 48'h10, 16'd4);
    push_wr(8'h10, 4, 8'hA1);
    push_ev(EV_WRS, 32'd4, 32'h0001025A);
    send(fr.size() - 1);
    stall = 1'b1;

    mk(8'h10, 8'h04, 16'd12, 8'h33, 8'h00, 16'h0304, 48'h40, 16'd8);
    push_ev(EV_RDS, 32'd8, 32'h00030433);
    send(15);

    // Non-RMA message is dropped silently
    mk(8'h10, 8'h02, 16'd16, 8'h01, 8'h10, 16'h0, 48'h0, 16'd4);
    for (int i = 0; i < 4; i++) fr.push_back(8'hEE);
    send(19);
    chk("busy_after_drop", 32'(busy), 0);

    // Early eof after two data bytes
    mk(8'h10, 8'h04, 16'd16, 8'h11, 8'h10, 16'h0505, 48'h20, 16'd4);
    push_wr(8'h20, 2, 8'hB1);
    push_ev(EV_ERR, 0, 0);
    send(fr.size() - 1);
    mk(8'h10, 8'h04, 16'd12, 8'h44, 8'h00, 16'h0606, 48'h0, 16'd1);
    push_ev(EV_RDS, 32'd1, 32'h00060644);
    send(15);

    // New sof at offset 9 aborts the read
    mk(8'h10, 8'h04, 16'd12, 8'h66, 8'h00, 16'h0707, 48'h0, 16'd8);
    while (fr.size() > 9) void'(fr.pop_back());
    push_ev(EV_ERR, 0, 0);
    send(-1);
    mk(8'h10, 8'h04, 16'd14, 8'h77, 8'h10, 16'h0808, 48'h30, 16'd2);
    push_wr(8'h30, 2, 8'hC1);
    push_ev(EV_WRS, 32'd2, 32'h00080877);
    send(fr.size() - 1);

    // Address wrap
    mk(8'h10, 8'h04, 16'd16, 8'h88, 8'h10, 16'h0909, 48'hFE, 16'd4);
    push_wr(8'hFE, 4, 8'hD0);
    push_ev(EV_WRS, 32'd4, 32'h00090988);
    send(fr.size() - 1);

    // Length above MAX_LEN
    mk(8'h10, 8'h04, 16'd77, 8'h01, 8'h10, 16'h0, 48'h0, 16'd65);
    push_ev(EV_ERR, 0, 0);
    send(15);
    // Length zero
    mk(8'h10, 8'h04, 16'd12, 8'h01, 8'h00, 16'h0, 48'h0, 16'd0);
    push_ev(EV_ERR, 0, 0);
    send(15);
    // Payload size mismatch on write
    mk(8'h10, 8'h04, 16'd20, 8'h01, 8'h10, 16'h0, 48'h0, 16'd4);
    for (int i = 0; i < 4; i++) fr.push_back(8'h55);
    push_ev(EV_ERR, 0, 0);
    send(fr.size() - 1);
    // Bad revision, then C bit set
    mk(8'h20, 8'h04, 16'd12, 8'h01, 8'h00, 16'h0, 48'h0, 16'd8);
    push_ev(EV_ERR, 0, 0);
    send(15);
    mk(8'h11, 8'h04, 16'd12, 8'h01, 8'h00, 16'h0, 48'h0, 16'd8);
    push_ev(EV_ERR, 0, 0);
    send(15);
    // Bad Req/Resp nibble
    mk(8'h10, 8'h04, 16'd12, 8'h01, 8'h01, 16'h0, 48'h0, 16'd8);
    push_ev(EV_ERR, 0, 0);
    send(15);
    // Single-byte frame
    fr.delete();
    fr.push_back(8'h10);
    push_ev(EV_ERR, 0, 0);
    send(0);
    // Read missing eof on offset 15
    mk(8'h10, 8'h04, 16'd12, 8'h01, 8'h00, 16'h0, 48'h0, 16'd8);
    fr.push_back(8'h00);
    fr.push_back(8'h00);
    push_ev(EV_ERR, 0, 0);
    send(17);

    mk(8'h10, 8'h04, 16'd12, 8'h99, 8'h00, 16'hABCD, 48'h0, 16'h20);
    push_ev(EV_RDS, 32'h20, 32'h00ABCD99);
    send(15);
    idle(5);
    chk("sb_empty", 32'(sb.size()), 0);

    // Reset in the middle of write data
    stall = 1'b0;
    mk(8'h10, 8'h04, 16'd16, 8'h12, 8'h10, 16'h0101, 48'h20, 16'd4);
    push_wr(8'h20, 2, 8'hE1);
    send(-1);
    idle(1);
    chk("busy_mid_data", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_wr_en", 32'(mem_wr_en), 0);
    chk("arst_addr", 32'(mem_addr), 0);
    chk("arst_wdata", 32'(mem_wdata), 0);
    chk("arst_len", 32'(tx_payload_len), 0);
    chk("arst_id", 32'(rma_id), 0);
    chk("arst_elem", 32'(element_id), 0);
    chk("arst_resp", 32'({send_write_resp, send_read_resp}), 0);
    idle(2);
    reset = 1'b0;
    idle(2);
    chk("sb_empty_end", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
